// File: rtl/verificacao_sequencia.sv
//==============================================================================
// Module      : verificacao_sequencia
// Description : Checks a stream of entered symbols against a captured
//               expected track. Mismatches are retried and counted; more
//               than MAX_ERR mismatches end the run in FALHA, matching the
//               whole track ends it in SUCESSO.
//               Optional macro VERIF_TIMEOUT_EN: an idle symbol slot of
//               TIMEOUT_CYC cycles counts as a mismatch.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module verificacao_sequencia #(
    parameter int SEQ_LEN     = 6,
    parameter int SYM_W       = 4,
    parameter int MAX_ERR     = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [SEQ_LEN*SYM_W-1:0]   pista,
    input  logic [SYM_W-1:0]           numero,
    input  logic                       numero_valid,
    output logic [2:0]                 estado,
    output logic [$clog2(SEQ_LEN)-1:0] posicao,
    output logic [3:0]                 num_erros,
    output logic                       erro_ocorrido,
    output logic                       sucesso,
    output logic                       falha
);

    localparam int POS_W = $clog2(SEQ_LEN);
    localparam logic [POS_W-1:0] ULTIMA    = POS_W'(SEQ_LEN - 1);
    localparam logic [4:0]       MAX_ERR_V = 5'(MAX_ERR);

    typedef enum logic [2:0] {
        IDLE         = 3'b000,
        VERIFICA     = 3'b001,
        SUCESSO      = 3'b010,
        ERRO_PARCIAL = 3'b011,
        FALHA        = 3'b100
    } state_t;

    state_t                     state, state_next;
    logic [SEQ_LEN*SYM_W-1:0]   pista_copia, pista_next;
    logic [POS_W-1:0]           pos_next;
    logic [3:0]                 erros_next;
    logic                       pulso_next;
    logic [SYM_W-1:0]           simbolo_esperado;
    logic                       verificando;
    logic                       acerto;
    logic                       erro;
    logic                       timeout_hit;

    // Symbols are only consumed while a run is active
    assign verificando = (state == VERIFICA) || (state == ERRO_PARCIAL);

    // Pick the expected symbol at the current position; symbol 0 sits in the MSBs
    always_comb begin
        simbolo_esperado = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (posicao == POS_W'(i)) begin
                simbolo_esperado = pista_copia[(SEQ_LEN-1-i)*SYM_W +: SYM_W];
            end
        end
    end

    // A timeout can only fire on a cycle without a valid symbol, so it never
    // coincides with a match
    assign acerto = verificando && numero_valid && (numero == simbolo_esperado);
    assign erro   = verificando && ((numero_valid && (numero != simbolo_esperado)) || timeout_hit);

`ifdef VERIF_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    assign timeout_hit = verificando && !numero_valid && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Count idle cycles inside a run; restart on symbols, timeouts and state entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (!verificando || numero_valid || timeout_hit || (state_next != state)) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and datapath updates; a cycle either advances or counts an error
    always_comb begin
        state_next = state;
        pista_next = pista_copia;
        pos_next   = posicao;
        erros_next = num_erros;
        pulso_next = 1'b0;
        case (state)
            IDLE, SUCESSO, FALHA: begin
                if (start) begin
                    pista_next = pista;
                    pos_next   = '0;
                    erros_next = '0;
                    state_next = VERIFICA;
                end
            end
            VERIFICA, ERRO_PARCIAL: begin
                if (acerto) begin
                    if (posicao == ULTIMA) begin
                        state_next = SUCESSO;
                    end else begin
                        pos_next = posicao + 1'b1;
                    end
                end else if (erro) begin
                    pulso_next = 1'b1;
                    erros_next = (num_erros == 4'hF) ? 4'hF : num_erros + 4'd1;
                    if ({1'b0, num_erros} >= MAX_ERR_V) begin
                        state_next = FALHA;
                    end else begin
                        state_next = ERRO_PARCIAL;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and run registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pista_copia   <= '0;
            posicao       <= '0;
            num_erros     <= '0;
            erro_ocorrido <= 1'b0;
        end else begin
            state         <= state_next;
            pista_copia   <= pista_next;
            posicao       <= pos_next;
            num_erros     <= erros_next;
            erro_ocorrido <= pulso_next;
        end
    end

    assign estado  = state;
    assign sucesso = (state == SUCESSO);
    assign falha   = (state == FALHA);

endmodule

`default_nettype wire

// File: tb/tb_verificacao_sequencia.sv
//==============================================================================
// Module      : tb_verificacao_sequencia
// Description : Directed stimulus with a queue-based scoreboard for
//               verificacao_sequencia (SEQ_LEN=6, SYM_W=4, MAX_ERR=1).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_verificacao_sequencia;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [23:0] pista;
    logic [3:0]  numero;
    logic        numero_valid;
    logic [2:0]  estado;
    logic [2:0]  posicao;
    logic [3:0]  num_erros;
    logic        erro_ocorrido;
    logic        sucesso;
    logic        falha;

    int total = 0;
    int bad   = 0;

    logic [12:0] exp_q[$];
    string       name_q[$];

    verificacao_sequencia #(
        .SEQ_LEN    (6),
        .SYM_W      (4),
        .MAX_ERR    (1),
        .TIMEOUT_CYC(10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .pista        (pista),
        .numero       (numero),
        .numero_valid (numero_valid),
        .estado       (estado),
        .posicao      (posicao),
        .num_erros    (num_erros),
        .erro_ocorrido(erro_ocorrido),
        .sucesso      (sucesso),
        .falha        (falha)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] pack(input logic [2:0] st, input logic [2:0] pos,
                                         input logic [3:0] ne, input logic er);
        // sucesso/falha are plain decodes of the state
        return {st, pos, ne, er, (st == 3'b010), (st == 3'b100)};
    endfunction

    function automatic logic [12:0] observed();
        return {estado, posicao, num_erros, erro_ocorrido, sucesso, falha};
    endfunction

    task automatic compare(input string nm, input logic [12:0] got, input logic [12:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got est=%b pos=%0d err=%0d pulse=%b suc=%b fal=%b, want est=%b pos=%0d err=%0d pulse=%b suc=%b fal=%b",
                     nm, got[12:10], got[9:7], got[6:3], got[2], got[1], got[0],
                     want[12:10], want[9:7], want[6:3], want[2], want[1], want[0]);
        end
    endtask

    // Drive one cycle of inputs and record the outputs expected after the edge
    task automatic apply(input logic s, input logic [23:0] p, input logic v, input logic [3:0] n,
                         input logic [2:0] st, input logic [2:0] pos, input logic [3:0] ne,
                         input logic er, input string nm);
        start        = s;
        pista        = p;
        numero_valid = v;
        numero       = n;
        exp_q.push_back(pack(st, pos, ne, er));
        name_q.push_back(nm);
        @(posedge clk);
    endtask

    task automatic step(input logic s, input logic [23:0] p, input logic v, input logic [3:0] n,
                        input logic [2:0] st, input logic [2:0] pos, input logic [3:0] ne,
                        input logic er, input string nm);
        @(negedge clk);
        apply(s, p, v, n, st, pos, ne, er, nm);
    endtask

    // Monitor: after each edge, pop the pending expectation and compare
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            compare(name_q.pop_front(), observed(), exp_q.pop_front());
        end
    end

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        pista        = 24'h0;
        numero       = 4'h0;
        numero_valid = 1'b0;
        #3;
        compare("reset_state", observed(), 13'b0);
        repeat (2) @(negedge clk);

        // First edge after reset release accepts start; valid on that cycle is ignored
        rst_n = 1'b1;
        apply(1, 24'h123456, 1, 4'h1, 3'b001, 3'd0, 4'd0, 0, "first_start");

        // Clean pass: 1..6
        for (int i = 1; i <= 5; i++)
            step(0, 24'h0, 1, 4'(i), 3'b001, 3'(i), 4'd0, 0, "clean_match");
        step(0, 24'h0, 1, 4'h6, 3'b010, 3'd5, 4'd0, 0, "clean_success");
        step(0, 24'h0, 1, 4'h3, 3'b010, 3'd5, 4'd0, 0, "success_hold");

        // One tolerated error: 1,9,2,3,4,5,6
        step(1, 24'h123456, 0, 4'h0, 3'b001, 3'd0, 4'd0, 0, "restart_a");
        step(0, 24'h0, 1, 4'h1, 3'b001, 3'd1, 4'd0, 0, "partial_m1");
        step(0, 24'h0, 1, 4'h9, 3'b011, 3'd1, 4'd1, 1, "partial_err");
        step(0, 24'h0, 1, 4'h2, 3'b011, 3'd2, 4'd1, 0, "partial_retry");
        step(0, 24'h0, 1, 4'h3, 3'b011, 3'd3, 4'd1, 0, "partial_m3");
        step(0, 24'h0, 1, 4'h4, 3'b011, 3'd4, 4'd1, 0, "partial_m4");
        step(0, 24'h0, 0, 4'h5, 3'b011, 3'd4, 4'd1, 0, "partial_wait");
        step(0, 24'h0, 1, 4'h5, 3'b011, 3'd5, 4'd1, 0, "partial_m5");
        step(0, 24'h0, 1, 4'h6, 3'b010, 3'd5, 4'd1, 0, "partial_success");

        // Failure: 1,9,8 then ignored input
        step(1, 24'h123456, 0, 4'h0, 3'b001, 3'd0, 4'd0, 0, "restart_b");
        step(0, 24'h0, 1, 4'h1, 3'b001, 3'd1, 4'd0, 0, "fail_m1");
        step(0, 24'h0, 1, 4'h9, 3'b011, 3'd1, 4'd1, 1, "fail_err1");
        step(0, 24'h0, 1, 4'h8, 3'b100, 3'd1, 4'd2, 1, "fail_err2");
        step(0, 24'h0, 1, 4'h2, 3'b100, 3'd1, 4'd2, 0, "fail_ignore_a");
        step(0, 24'h0, 1, 4'h7, 3'b100, 3'd1, 4'd2, 0, "fail_ignore_b");

        // Restart from FALHA with a new track
        step(1, 24'hAAAAAA, 0, 4'h0, 3'b001, 3'd0, 4'd0, 0, "restart_from_fail");
        for (int i = 1; i <= 5; i++)
            step(0, 24'h0, 1, 4'hA, 3'b001, 3'(i), 4'd0, 0, "aaa_match");
        step(0, 24'h0, 1, 4'hA, 3'b010, 3'd5, 4'd0, 0, "aaa_success");

        // Start ignored mid-run, pista changes do not affect the run, then async reset
        step(1, 24'h123456, 0, 4'h0, 3'b001, 3'd0, 4'd0, 0, "restart_c");
        step(0, 24'h0, 1, 4'h1, 3'b001, 3'd1, 4'd0, 0, "mid_m1");
        step(0, 24'h0, 1, 4'h2, 3'b001, 3'd2, 4'd0, 0, "mid_m2");
        step(0, 24'h0, 1, 4'h3, 3'b001, 3'd3, 4'd0, 0, "mid_m3");
        step(1, 24'hAAAAAA, 0, 4'h0, 3'b001, 3'd3, 4'd0, 0, "start_ignored");
        step(0, 24'hAAAAAA, 1, 4'h4, 3'b001, 3'd4, 4'd0, 0, "pista_frozen");
        step(0, 24'h0, 1, 4'h7, 3'b011, 3'd4, 4'd1, 1, "pre_reset_err");
        @(negedge clk);
        start        = 1'b0;
        numero_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        compare("async_reset", observed(), 13'b0);
        @(negedge clk);
        compare("reset_held", observed(), 13'b0);
        rst_n = 1'b1;
        apply(1, 24'h654321, 0, 4'h0, 3'b001, 3'd0, 4'd0, 0, "post_reset_start");
        step(0, 24'h0, 1, 4'h6, 3'b001, 3'd1, 4'd0, 0, "post_reset_m");

        // Let the monitor drain the queue, bounded
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
